// File: rtl/mem_pkg.sv
// Shared widths and the pending-store entry layout for the store buffer.
package mem_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 32;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/mem_store_buffer_if.sv
// Pipeline-side requests and data-memory port of the store buffer.
interface mem_store_buffer_if #(
  parameter int ADDR_W = mem_pkg::MEM_ADDR_W,
  parameter int DATA_W = mem_pkg::MEM_DATA_W
) ();

  logic              req_read;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              stall;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              empty;

  modport slave (
    input  req_read, req_write, req_addr, req_wdata, mem_rdata,
    output stall, load_valid, load_data, mem_read, mem_write, mem_addr, mem_wdata, empty
  );

  modport master (
    output req_read, req_write, req_addr, req_wdata, mem_rdata,
    input  stall, load_valid, load_data, mem_read, mem_write, mem_addr, mem_wdata, empty
  );

endinterface

// File: rtl/sb_match.sv
// Youngest-match search over the valid store-buffer entries for a load address.
module sb_match
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  sb_entry_t             entries [DEPTH],
  input  logic [PTR_W-1:0]      head,
  input  logic [CNT_W-1:0]      count,
  input  logic [MEM_ADDR_W-1:0] addr,
  output logic                  hit,
  output logic [MEM_DATA_W-1:0] data
);

  // Slot gi holds the gi-th oldest entry, so the highest matching slot is the youngest.
  logic [DEPTH-1:0]      match_age;
  logic [MEM_DATA_W-1:0] age_data [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      logic [PTR_W-1:0] idx;
      assign idx           = head + PTR_W'(gi);
      assign match_age[gi] = (CNT_W'(gi) < count) && (entries[idx].addr == addr);
      assign age_data[gi]  = entries[idx].data;
    end
  endgenerate

  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match_age[k]) begin
        hit  = 1'b1;
        data = age_data[k];
      end
    end
  end

endmodule

// File: rtl/mem_store_buffer.sv
// Circular store buffer between pipeline and data memory: loads take the memory
// port first, pending stores drain in order on idle cycles, loads forward from stores.
module mem_store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_store_buffer_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t         entries [DEPTH];
  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              load_valid_reg;
  logic [DATA_W-1:0] load_data_reg;

  logic              full;
  logic              push;
  logic              pop;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign full = (count_reg == CNT_W'(DEPTH));
  assign push = bus.req_write & ~full;
  // Draining is suppressed while reset is asserted so no stale store reaches memory.
  assign pop  = ~bus.req_read & (count_reg != '0) & rst_n;

  assign bus.stall      = bus.req_write & full;
  assign bus.empty      = (count_reg == '0);
  assign bus.load_valid = load_valid_reg;
  assign bus.load_data  = load_data_reg;

  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (bus.req_read) begin
      bus.mem_read = 1'b1;
      bus.mem_addr = bus.req_addr;
    end else if (pop) begin
      bus.mem_write = 1'b1;
      bus.mem_addr  = entries[head_reg].addr;
      bus.mem_wdata = entries[head_reg].data;
    end
  end

  sb_match #(.DEPTH(DEPTH)) u_match (
    .entries (entries),
    .head    (head_reg),
    .count   (count_reg),
    .addr    (bus.req_addr),
    .hit     (fwd_hit),
    .data    (fwd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      load_valid_reg <= 1'b0;
      load_data_reg  <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
      count_reg      <= count_reg + CNT_W'(push) - CNT_W'(pop);
      load_valid_reg <= bus.req_read;
      if (bus.req_read) load_data_reg <= fwd_hit ? fwd_data : bus.mem_rdata;
    end
  end

  // Entry storage is never cleared; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (push) entries[tail_reg] <= '{addr: bus.req_addr, data: bus.req_wdata};
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed + random bench for mem_store_buffer against a queue-based reference model.
module tb_mem_store_buffer;
  import mem_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_store_buffer_if bus ();

  mem_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Data memory seen by the DUT; reads are combinational
  logic [31:0] tb_mem  [256];
  logic [31:0] ref_mem [256];
  assign bus.mem_rdata = tb_mem[bus.mem_addr];

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } st_t;

  st_t         q[$];
  logic        exp_lv;
  logic [31:0] exp_ld;
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [7:0] a,
                      input logic [31:0] d, input logic rn);
    logic        e_stall, do_push, do_pop, mw;
    logic [7:0]  e_ma, ma;
    logic [31:0] e_wd, fwd, wd;
    bus.req_read  = r;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    rst_n         = rn;
    e_stall = w && (q.size() == DEPTH);
    do_push = w && (q.size() < DEPTH);
    do_pop  = !r && rn && (q.size() > 0);
    e_ma    = r ? a : (do_pop ? q[0].a : 8'h00);
    e_wd    = do_pop ? q[0].d : 32'h0;
    fwd     = ref_mem[a];
    foreach (q[i]) if (q[i].a == a) fwd = q[i].d;
    @(negedge clk);
    chk("stall",      32'(bus.stall),      32'(e_stall));
    chk("mem_read",   32'(bus.mem_read),   32'(r));
    chk("mem_write",  32'(bus.mem_write),  32'(do_pop));
    chk("mem_addr",   32'(bus.mem_addr),   32'(e_ma));
    chk("mem_wdata",  bus.mem_wdata,       e_wd);
    chk("empty",      32'(bus.empty),      32'(q.size() == 0));
    chk("load_valid", 32'(bus.load_valid), 32'(exp_lv));
    chk("load_data",  bus.load_data,       exp_ld);
    mw = bus.mem_write;
    ma = bus.mem_addr;
    wd = bus.mem_wdata;
    @(posedge clk);
    #1;
    if (mw) tb_mem[ma] = wd;
    if (!rn) begin
      q.delete();
      exp_lv = 1'b0;
      exp_ld = 32'h0;
    end else begin
      exp_lv = r;
      if (r) exp_ld = fwd;
      if (do_pop) begin
        ref_mem[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (do_push) q.push_back('{a: a, d: d});
    end
    cyc++;
    $display("[TB] cyc %0d rd=%0b wr=%0b addr=%02h wdata=%08h rst_n=%0b pending=%0d",
             cyc, r, w, a, d, rn, q.size());
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[7]  = 32'h1234;
    ref_mem[7] = 32'h1234;
    bus.req_read  = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    exp_lv = 1'b0;
    exp_ld = 32'h0;

    // Reset state, then a single store drained on the next idle cycle
    step(0, 0, 8'h00, 32'h0, 0);
    step(0, 0, 8'h00, 32'h0, 1);
    step(0, 1, 8'h05, 32'h11, 1);
    step(0, 0, 8'h00, 32'h0, 1);
    step(0, 0, 8'h00, 32'h0, 1);

    // Fill with loads holding off the drain; fifth store must stall
    for (int i = 0; i < 5; i++) step(1, 1, 8'h20 + 8'(i), 32'hC0 + 32'(i), 1);
    repeat (DEPTH + 1) step(0, 0, 8'h00, 32'h0, 1);

    // Two stores to one address, then a load forwards the younger one
    step(1, 1, 8'h03, 32'hA, 1);
    step(1, 1, 8'h03, 32'hB, 1);
    step(1, 0, 8'h03, 32'h0, 1);
    chk("fwd_youngest_valid", 32'(bus.load_valid), 32'h1);
    chk("fwd_youngest_data",  bus.load_data,       32'hB);
    repeat (3) step(0, 0, 8'h00, 32'h0, 1);

    // Load with no pending match comes from memory
    step(1, 0, 8'h07, 32'h0, 1);
    chk("nomatch_data", bus.load_data, 32'h1234);

    // Full buffer discarded by reset; no memory write during or after
    for (int i = 0; i < DEPTH; i++) step(1, 1, 8'h50 + 8'(i), 32'hD0 + 32'(i), 1);
    step(0, 0, 8'h00, 32'h0, 0);
    step(0, 0, 8'h00, 32'h0, 1);
    step(0, 1, 8'h60, 32'h66, 1);
    step(0, 0, 8'h00, 32'h0, 1);

    // Back-to-back store+drain across pointer wrap, repeated addresses
    for (int i = 0; i < DEPTH + 3; i++) step(0, 1, 8'h70 + 8'(i % 3), $urandom, 1);
    repeat (2) step(0, 0, 8'h00, 32'h0, 1);

    // Random traffic over a small address window
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 63) != 0));
    end
    repeat (DEPTH + 1) step(0, 0, 8'h00, 32'h0, 1);

    for (int i = 0; i < 256; i++) chk($sformatf("mem[%0d]", i), tb_mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_store_buffer.md
MEM_STORE_BUFFER -- requirements
Module: mem_store_buffer

Interface
REQ-001 DEPTH, default 4, number of pending-store entries (power of two, >=2) SHALL be a parameter.
REQ-002 ADDR_W, default 8, word-address width SHALL be a parameter.
REQ-003 DATA_W, default 32, data width SHALL be a parameter.
REQ-004 clk  in  1  sole clock; all state SHALL change on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 req_read  in  1  pipeline load request this cycle.
REQ-007 req_write  in  1  pipeline store request this cycle.
REQ-008 req_addr  in  ADDR_W  load/store address.
REQ-009 req_wdata  in  DATA_W  store data.
REQ-010 stall  out  1  store not accepted this cycle; pipeline SHALL hold.
REQ-011 load_valid  out  1  load_data valid, one cycle after load request.
REQ-012 load_data  out  DATA_W  load result.
REQ-013 mem_read  out  1  read strobe to data memory.
REQ-014 mem_write  out  1  write strobe to data memory.
REQ-015 mem_addr  out  ADDR_W  data memory address.
REQ-016 mem_wdata  out  DATA_W  data memory write data.
REQ-017 mem_rdata  in  DATA_W  data memory read data, valid same cycle as mem_read.
REQ-018 empty  out  1  no pending stores.

Function
REQ-019 Buffer SHALL be a circular FIFO of DEPTH {addr,data} entries with head/tail pointers and count 0..DEPTH; pointers wrap modulo DEPTH.
REQ-020 Store accepted when req_write=1 and count<DEPTH; entry written at tail at the edge; stall=0.
REQ-021 stall SHALL be combinational: req_write & (count==DEPTH); a pop in the same cycle does not clear stall.
REQ-022 Load port priority: req_read=1 drives mem_read=1, mem_addr=req_addr, mem_write=0.
REQ-023 Drain: req_read=0 and count>0 drive mem_write=1, mem_addr/mem_wdata=head entry; head popped at that edge.
REQ-024 Idle (req_read=0, count=0): mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-025 Load forwarding: if any valid entry matches req_addr, the youngest matching entry's data SHALL be registered into load_data; else mem_rdata.
REQ-026 Load latency exactly 1 cycle: load_valid=1 in the cycle after req_read=1, else 0.
REQ-027 Simultaneous req_read and req_write: load sees only entries existing before this cycle; store enqueued per REQ-020.
REQ-028 Simultaneous accepted store and drain pop: count unchanged, both pointers advance.
REQ-029 Stores to the same address SHALL NOT coalesce; memory writes occur in program order.
REQ-030 empty SHALL equal (count==0), registered-state derived.

Reset
REQ-031 On rst_n=0 at an edge: count=0, head=tail=0, load_valid=0, load_data=0; pending stores discarded.
REQ-032 During reset mid-drain, mem_write SHALL be 0 from the cycle rst_n is sampled low through release.
REQ-033 Entry storage need not be cleared; valid tracking via count only.

Structure
REQ-034 ADDR_W/DATA_W defaults and entry struct SHALL live in shared package mem_pkg.
REQ-035 One sub-module, sb_match, SHALL perform youngest-match search (DEPTH compares + priority select).
REQ-036 No latches; outputs other than load_valid/load_data/empty SHALL be combinational from state and requests.

Verification
REQ-037 Reset then store 0x11->addr 5 -> next cycle idle: mem_write=1, mem_addr=5, mem_wdata=0x11; empty=1 after.
REQ-038 5 consecutive stores with req_read=1 held (no drain), DEPTH=4 -> 5th: stall=1, count stays 4.
REQ-039 Store 0xA->addr 3, store 0xB->addr 3, load addr 3 before drain -> load_data=0xB, load_valid=1 one cycle later.
REQ-040 Load addr 7 with memory word 0x1234 and no match -> load_data=0x1234.
REQ-041 Full buffer, rst_n=0 one cycle -> empty=1, stall=0, no further mem_write.
REQ-042 DEPTH+3 store/drain cycles -> pointer wrap, memory contents in program order.
